// File: rtl/imager_pkg.sv
// Shared types and constants for the imager run-control sequencer.
package imager_pkg;

    typedef enum logic [1:0] {IDLE, RUN, STOPPING} seq_state_e;

    localparam logic [2:0] MODE_NOISE  = 3'd0;
    localparam logic [2:0] MODE_HGRAD  = 3'd1;
    localparam logic [2:0] MODE_VGRAD  = 3'd2;
    localparam logic [2:0] MODE_DGRAD  = 3'd3;
    localparam logic [2:0] MODE_FRAME  = 3'd4;
    localparam logic [2:0] MODE_DFRAME = 3'd5;

    localparam int unsigned MIN_VIRTUAL_ROWS = 1;
    localparam int unsigned MIN_VIRTUAL_COLS = 2;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/imager_seq_if.sv
// Host-side bundle of the sequencer: config writes, run commands and status.
interface imager_seq_if #(
    parameter int unsigned NUM_ROWS_WIDTH = 12,
    parameter int unsigned NUM_COLS_WIDTH = 12
);
    logic                      cfg_we;
    logic [2:0]                cfg_mode;
    logic [NUM_ROWS_WIDTH-1:0] cfg_active_rows;
    logic [NUM_ROWS_WIDTH-1:0] cfg_virtual_rows;
    logic [NUM_COLS_WIDTH-1:0] cfg_active_cols;
    logic [NUM_COLS_WIDTH-1:0] cfg_virtual_cols;
    logic [31:0]               cfg_noise_seed;
    logic                      start;
    logic                      stop;
    logic [15:0]               num_frames;
    logic                      busy;
    logic                      done;
    logic                      cfg_pending;
    logic                      cfg_err;
    logic                      frame_err;
    logic [15:0]               frame_count;

    modport master (
        output cfg_we, cfg_mode, cfg_active_rows, cfg_virtual_rows, cfg_active_cols,
               cfg_virtual_cols, cfg_noise_seed, start, stop, num_frames,
        input  busy, done, cfg_pending, cfg_err, frame_err, frame_count
    );

    modport slave (
        input  cfg_we, cfg_mode, cfg_active_rows, cfg_virtual_rows, cfg_active_cols,
               cfg_virtual_cols, cfg_noise_seed, start, stop, num_frames,
        output busy, done, cfg_pending, cfg_err, frame_err, frame_count
    );
endinterface

// File: rtl/imager_cfg_shadow.sv
// Staged/applied configuration pair: validates host writes, holds them until the
// sequencer strobes apply at a safe point.
module imager_cfg_shadow
    import imager_pkg::*;
#(
    parameter int unsigned NUM_ROWS_WIDTH   = 12,
    parameter int unsigned NUM_COLS_WIDTH   = 12,
    parameter int unsigned RST_ACTIVE_ROWS  = 480,
    parameter int unsigned RST_VIRTUAL_ROWS = 45,
    parameter int unsigned RST_ACTIVE_COLS  = 640,
    parameter int unsigned RST_VIRTUAL_COLS = 160
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      cfg_we,
    input  logic [2:0]                cfg_mode,
    input  logic [NUM_ROWS_WIDTH-1:0] cfg_active_rows,
    input  logic [NUM_ROWS_WIDTH-1:0] cfg_virtual_rows,
    input  logic [NUM_COLS_WIDTH-1:0] cfg_active_cols,
    input  logic [NUM_COLS_WIDTH-1:0] cfg_virtual_cols,
    input  logic [31:0]               cfg_noise_seed,
    input  logic                      apply,
    output logic                      cfg_pending,
    output logic                      cfg_err,
    output logic [2:0]                img_mode,
    output logic [NUM_ROWS_WIDTH-1:0] img_active_rows,
    output logic [NUM_ROWS_WIDTH-1:0] img_virtual_rows,
    output logic [NUM_COLS_WIDTH-1:0] img_active_cols,
    output logic [NUM_COLS_WIDTH-1:0] img_virtual_cols,
    output logic [31:0]               img_noise_seed
);

    localparam int unsigned CfgW = 3 + 2 * NUM_ROWS_WIDTH + 2 * NUM_COLS_WIDTH + 32;
    localparam logic [CfgW-1:0] RstCfg = {MODE_NOISE,
                                          NUM_ROWS_WIDTH'(RST_ACTIVE_ROWS),
                                          NUM_ROWS_WIDTH'(RST_VIRTUAL_ROWS),
                                          NUM_COLS_WIDTH'(RST_ACTIVE_COLS),
                                          NUM_COLS_WIDTH'(RST_VIRTUAL_COLS),
                                          32'd0};

    logic [CfgW-1:0] cfg_in, staged_q, staged_d, applied_q, applied_d;
    logic            pending_q, pending_d, err_q, err_d;
    logic            valid, accept;

    assign cfg_in = {cfg_mode, cfg_active_rows, cfg_virtual_rows, cfg_active_cols,
                     cfg_virtual_cols, cfg_noise_seed};

    assign valid = (cfg_mode <= MODE_DFRAME) && (cfg_active_rows != '0) &&
                   (cfg_active_cols != '0) &&
                   (cfg_virtual_rows >= NUM_ROWS_WIDTH'(MIN_VIRTUAL_ROWS)) &&
                   (cfg_virtual_cols >= NUM_COLS_WIDTH'(MIN_VIRTUAL_COLS));
    assign accept = cfg_we && valid;

    // Apply takes the old staged value, so a write on the apply cycle stays pending.
    always_comb begin
        staged_d  = accept ? cfg_in : staged_q;
        applied_d = apply ? staged_q : applied_q;
        pending_d = accept ? 1'b1 : (apply ? 1'b0 : pending_q);
        err_d     = cfg_we && !valid;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            staged_q  <= RstCfg;
            applied_q <= RstCfg;
            pending_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            staged_q  <= staged_d;
            applied_q <= applied_d;
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

    assign cfg_pending = pending_q;
    assign cfg_err     = err_q;
    assign {img_mode, img_active_rows, img_virtual_rows, img_active_cols, img_virtual_cols,
            img_noise_seed} = applied_q;

endmodule

// File: rtl/imager_seq.sv
// Run-control sequencer for the imager: starts/stops runs, counts frames and lines
// from fv/lv, and swaps in new configuration only at frame boundaries.
module imager_seq
    import imager_pkg::*;
#(
    parameter int unsigned NUM_ROWS_WIDTH   = 12,
    parameter int unsigned NUM_COLS_WIDTH   = 12,
    parameter int unsigned RST_ACTIVE_ROWS  = 480,
    parameter int unsigned RST_VIRTUAL_ROWS = 45,
    parameter int unsigned RST_ACTIVE_COLS  = 640,
    parameter int unsigned RST_VIRTUAL_COLS = 160
) (
    input  logic                      clk,
    input  logic                      reset_n,
    imager_seq_if.slave               host,
    input  logic                      fv,
    input  logic                      lv,
    output logic                      img_enable,
    output logic [2:0]                img_mode,
    output logic [NUM_ROWS_WIDTH-1:0] img_active_rows,
    output logic [NUM_ROWS_WIDTH-1:0] img_virtual_rows,
    output logic [NUM_COLS_WIDTH-1:0] img_active_cols,
    output logic [NUM_COLS_WIDTH-1:0] img_virtual_cols,
    output logic [31:0]               img_noise_seed
);

    seq_state_e                state_q, state_d;
    logic                      fv_q, lv_q;
    logic [NUM_ROWS_WIDTH-1:0] line_cnt_q, line_cnt_d;
    logic [15:0]               frame_count_q, frame_count_d, fc_inc;
    logic [15:0]               num_frames_q, num_frames_d;
    logic                      done_q, done_d, frame_err_q, frame_err_d;
    logic                      boundary, lv_rise, apply, cfg_pending, cfg_err;

    assign boundary = fv_q && !fv;
    assign lv_rise  = lv && !lv_q && fv;
    assign fc_inc   = sat_inc16(frame_count_q);

    always_comb begin
        state_d       = state_q;
        line_cnt_d    = line_cnt_q;
        frame_count_d = frame_count_q;
        num_frames_d  = num_frames_q;
        done_d        = 1'b0;
        frame_err_d   = 1'b0;
        apply         = 1'b0;
        unique case (state_q)
            IDLE: begin
                apply = cfg_pending;
                if (host.start) begin
                    state_d       = RUN;
                    num_frames_d  = host.num_frames;
                    frame_count_d = '0;
                    line_cnt_d    = '0;
                end
            end
            RUN, STOPPING: begin
                if (lv_rise) line_cnt_d = line_cnt_q + 1'b1;
                if (boundary) begin
                    frame_count_d = fc_inc;
                    frame_err_d   = (line_cnt_q != img_active_rows);
                    line_cnt_d    = '0;
                    apply         = cfg_pending;
                    if (state_q == STOPPING || (num_frames_q != '0 && fc_inc == num_frames_q))
                        state_d = IDLE;
                end
                // A stop landing on the final boundary is already covered above.
                if (state_q == RUN && host.stop && state_d != IDLE)
                    state_d = fv ? STOPPING : IDLE;
                done_d = (state_d == IDLE);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            fv_q          <= 1'b0;
            lv_q          <= 1'b0;
            line_cnt_q    <= '0;
            frame_count_q <= '0;
            num_frames_q  <= '0;
            done_q        <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            fv_q          <= fv;
            lv_q          <= lv;
            line_cnt_q    <= line_cnt_d;
            frame_count_q <= frame_count_d;
            num_frames_q  <= num_frames_d;
            done_q        <= done_d;
            frame_err_q   <= frame_err_d;
        end
    end

    imager_cfg_shadow #(
        .NUM_ROWS_WIDTH  (NUM_ROWS_WIDTH),
        .NUM_COLS_WIDTH  (NUM_COLS_WIDTH),
        .RST_ACTIVE_ROWS (RST_ACTIVE_ROWS),
        .RST_VIRTUAL_ROWS(RST_VIRTUAL_ROWS),
        .RST_ACTIVE_COLS (RST_ACTIVE_COLS),
        .RST_VIRTUAL_COLS(RST_VIRTUAL_COLS)
    ) u_cfg_shadow (
        .clk             (clk),
        .reset_n         (reset_n),
        .cfg_we          (host.cfg_we),
        .cfg_mode        (host.cfg_mode),
        .cfg_active_rows (host.cfg_active_rows),
        .cfg_virtual_rows(host.cfg_virtual_rows),
        .cfg_active_cols (host.cfg_active_cols),
        .cfg_virtual_cols(host.cfg_virtual_cols),
        .cfg_noise_seed  (host.cfg_noise_seed),
        .apply           (apply),
        .cfg_pending     (cfg_pending),
        .cfg_err         (cfg_err),
        .img_mode        (img_mode),
        .img_active_rows (img_active_rows),
        .img_virtual_rows(img_virtual_rows),
        .img_active_cols (img_active_cols),
        .img_virtual_cols(img_virtual_cols),
        .img_noise_seed  (img_noise_seed)
    );

    assign img_enable       = (state_q != IDLE);
    assign host.busy        = (state_q != IDLE);
    assign host.done        = done_q;
    assign host.frame_err   = frame_err_q;
    assign host.frame_count = frame_count_q;
    assign host.cfg_pending = cfg_pending;
    assign host.cfg_err     = cfg_err;

endmodule

// File: tb/tb_imager_seq.sv
// Directed bench for imager_seq: the stimulus thread pushes expected pulse events,
// a negedge monitor pops and compares them; level checks are made inline.
module tb_imager_seq;

    logic        clk;
    logic        reset_n;
    logic        fv, lv;
    logic        img_enable;
    logic [2:0]  img_mode;
    logic [11:0] img_active_rows, img_virtual_rows, img_active_cols, img_virtual_cols;
    logic [31:0] img_noise_seed;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string       name;
        bit          done;
        bit          ferr;
        bit          cerr;
        bit          chk_fc;
        logic [15:0] fc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    imager_seq_if host_if ();

    imager_seq dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .host            (host_if.slave),
        .fv              (fv),
        .lv              (lv),
        .img_enable      (img_enable),
        .img_mode        (img_mode),
        .img_active_rows (img_active_rows),
        .img_virtual_rows(img_virtual_rows),
        .img_active_cols (img_active_cols),
        .img_virtual_cols(img_virtual_cols),
        .img_noise_seed  (img_noise_seed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_evt(input string name, input bit d, input bit fe, input bit ce,
                              input bit chk, input logic [15:0] fc);
        exp_t e;
        e.name = name; e.done = d; e.ferr = fe; e.cerr = ce; e.chk_fc = chk; e.fc = fc;
        exp_q.push_back(e);
    endtask

    task automatic write_cfg(input logic [2:0] m, input logic [11:0] ar, input logic [11:0] vr,
                             input logic [11:0] ac, input logic [11:0] vc,
                             input logic [31:0] seed);
        host_if.cfg_mode         = m;
        host_if.cfg_active_rows  = ar;
        host_if.cfg_virtual_rows = vr;
        host_if.cfg_active_cols  = ac;
        host_if.cfg_virtual_cols = vc;
        host_if.cfg_noise_seed   = seed;
        host_if.cfg_we           = 1'b1;
        tick();
        host_if.cfg_we = 1'b0;
    endtask

    task automatic start_run(input logic [15:0] n);
        host_if.num_frames = n;
        host_if.start      = 1'b1;
        tick();
        host_if.start = 1'b0;
    endtask

    task automatic fv_start();
        fv = 1'b1; lv = 1'b0;
        tick();
    endtask

    task automatic lines(input int n);
        for (int l = 0; l < n; l++) begin
            lv = 1'b1; repeat (2) tick();
            lv = 1'b0; repeat (2) tick();
        end
    endtask

    // Returns one cycle after the boundary, when registered results are visible.
    task automatic fv_end();
        fv = 1'b0; lv = 1'b0;
        tick();
    endtask

    task automatic frame(input int n);
        fv_start(); lines(n); fv_end();
    endtask

    always @(negedge clk) begin
        if (reset_n && (host_if.done || host_if.frame_err || host_if.cfg_err)) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_event: got done=%0b frame_err=%0b cfg_err=%0b expected none",
                         host_if.done, host_if.frame_err, host_if.cfg_err);
            end else begin
                mon_e = exp_q.pop_front();
                if ({host_if.done, host_if.frame_err, host_if.cfg_err} !==
                        {mon_e.done, mon_e.ferr, mon_e.cerr} ||
                    (mon_e.chk_fc && host_if.frame_count !== mon_e.fc)) begin
                    fails++;
                    $display("FAIL %s: got done=%0b ferr=%0b cerr=%0b fc=%0d expected %0b %0b %0b fc=%0d",
                             mon_e.name, host_if.done, host_if.frame_err, host_if.cfg_err,
                             host_if.frame_count, mon_e.done, mon_e.ferr, mon_e.cerr, mon_e.fc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; fv = 1'b0; lv = 1'b0;
        host_if.cfg_we = 1'b0; host_if.cfg_mode = '0;
        host_if.cfg_active_rows = '0; host_if.cfg_virtual_rows = '0;
        host_if.cfg_active_cols = '0; host_if.cfg_virtual_cols = '0;
        host_if.cfg_noise_seed = '0; host_if.start = 1'b0; host_if.stop = 1'b0;
        host_if.num_frames = '0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        check("rst_enable", 32'(img_enable), 32'd0);
        check("rst_busy", 32'(host_if.busy), 32'd0);
        check("rst_pending", 32'(host_if.cfg_pending), 32'd0);
        check("rst_frame_count", 32'(host_if.frame_count), 32'd0);
        check("rst_mode", 32'(img_mode), 32'd0);
        check("rst_seed", img_noise_seed, 32'd0);
        check("rst_geom", {img_active_rows, img_virtual_rows[7:0], img_active_cols[11:0]},
              {12'd480, 8'd45, 12'd640});
        check("rst_vcols", 32'(img_virtual_cols), 32'd160);

        // Idle config write: pending at t+1, applied at t+2.
        write_cfg(3'd1, 12'd4, 12'd2, 12'd2, 12'd4, 32'hCAFE);
        check("idle_pending_t1", 32'(host_if.cfg_pending), 32'd1);
        check("idle_mode_t1", 32'(img_mode), 32'd0);
        tick();
        check("idle_mode_t2", 32'(img_mode), 32'd1);
        check("idle_rows_t2", 32'(img_active_rows), 32'd4);
        check("idle_seed_t2", img_noise_seed, 32'hCAFE);
        check("idle_pending_t2", 32'(host_if.cfg_pending), 32'd0);

        // Bounded run of 3 frames.
        expect_evt("bounded_done", 1, 0, 0, 1, 16'd3);
        start_run(16'd3);
        check("start_busy", 32'(host_if.busy), 32'd1);
        check("start_enable", 32'(img_enable), 32'd1);
        frame(4);
        check("bounded_fc1", 32'(host_if.frame_count), 32'd1);
        repeat (3) tick();
        frame(4);
        repeat (3) tick();
        frame(4);
        check("bounded_fc3", 32'(host_if.frame_count), 32'd3);
        check("bounded_enable_off", 32'(img_enable), 32'd0);
        check("bounded_busy_off", 32'(host_if.busy), 32'd0);
        repeat (4) tick();

        // Continuous run, mode change mid-frame, then stop in vertical blank.
        expect_evt("vblank_stop_done", 1, 0, 0, 1, 16'd2);
        start_run(16'd0);
        frame(4);
        repeat (2) tick();
        fv_start();
        lines(2);
        write_cfg(3'd4, 12'd4, 12'd2, 12'd2, 12'd4, 32'hCAFE);
        check("midrun_pending", 32'(host_if.cfg_pending), 32'd1);
        lines(2);
        check("midrun_mode_held", 32'(img_mode), 32'd1);
        fv_end();
        check("midrun_mode_applied", 32'(img_mode), 32'd4);
        check("midrun_pending_clr", 32'(host_if.cfg_pending), 32'd0);
        tick();
        host_if.stop = 1'b1;
        tick();
        host_if.stop = 1'b0;
        check("vblank_stop_busy", 32'(host_if.busy), 32'd0);
        check("vblank_stop_fc", 32'(host_if.frame_count), 32'd2);
        repeat (3) tick();

        // Rejected writes leave applied config and pending untouched.
        expect_evt("rej_vcols", 0, 0, 1, 0, 16'd0);
        write_cfg(3'd2, 12'd4, 12'd2, 12'd2, 12'd1, 32'h1);
        check("rej_vcols_err", 32'(host_if.cfg_err), 32'd1);
        expect_evt("rej_arows", 0, 0, 1, 0, 16'd0);
        write_cfg(3'd2, 12'd0, 12'd2, 12'd2, 12'd4, 32'h1);
        expect_evt("rej_mode", 0, 0, 1, 0, 16'd0);
        write_cfg(3'd6, 12'd4, 12'd2, 12'd2, 12'd4, 32'h1);
        tick();
        check("rej_pending", 32'(host_if.cfg_pending), 32'd0);
        check("rej_mode_kept", 32'(img_mode), 32'd4);
        check("rej_vcols_kept", 32'(img_virtual_cols), 32'd4);
        check("rej_seed_kept", img_noise_seed, 32'hCAFE);

        // Stop while fv is high: frame completes, then done.
        expect_evt("fv_stop_done", 1, 0, 0, 1, 16'd1);
        start_run(16'd0);
        fv_start();
        lines(2);
        host_if.stop = 1'b1;
        tick();
        host_if.stop = 1'b0;
        check("fv_stop_still_busy", 32'(host_if.busy), 32'd1);
        lines(2);
        fv_end();
        check("fv_stop_busy_off", 32'(host_if.busy), 32'd0);
        check("fv_stop_fc", 32'(host_if.frame_count), 32'd1);
        repeat (3) tick();

        // Malformed frame: one line short.
        expect_evt("short_frame", 0, 1, 0, 1, 16'd1);
        start_run(16'd2);
        frame(3);
        check("short_frame_err", 32'(host_if.frame_err), 32'd1);
        repeat (3) tick();
        expect_evt("after_short_done", 1, 0, 0, 1, 16'd2);
        frame(4);
        check("after_short_busy", 32'(host_if.busy), 32'd0);
        repeat (3) tick();

        // Reset mid-frame, then restart.
        start_run(16'd0);
        frame(4);
        repeat (2) tick();
        fv_start();
        lines(1);
        #2 reset_n = 1'b0;
        #1;
        check("mrst_enable", 32'(img_enable), 32'd0);
        check("mrst_busy", 32'(host_if.busy), 32'd0);
        check("mrst_fc", 32'(host_if.frame_count), 32'd0);
        check("mrst_mode", 32'(img_mode), 32'd0);
        check("mrst_rows", 32'(img_active_rows), 32'd480);
        fv = 1'b0; lv = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        write_cfg(3'd3, 12'd4, 12'd2, 12'd2, 12'd4, 32'h55);
        repeat (2) tick();
        check("restart_mode", 32'(img_mode), 32'd3);
        expect_evt("restart_done", 1, 0, 0, 1, 16'd1);
        start_run(16'd1);
        frame(4);
        check("restart_fc", 32'(host_if.frame_count), 32'd1);
        check("restart_enable_off", 32'(img_enable), 32'd0);
        repeat (4) tick();

        check("events_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
